pixel_stream_gen: RTL and testbench
===================================

# pixel_stream_gen

Synthesizable RGB888 line/frame source for the image-preprocessing chain. It emits `img_width` pixels per line for `num_lines` lines, with a programmable idle gap between lines. Its output matches the `din_valid` / `r_data` / `g_data` / `b_data` input of the preprocessing stage and connects to it directly. Uses: on-chip bring-up stimulus, and standing in for the camera path in system tests.

## Interface
- `WIDTH_W`, default 12: width of pixel/line counters and size inputs.
- `GAP_W`, default 8: width of the idle-cycle count.
- `LFSR_SEED`, default 24'h5A5A5A: nonzero LFSR reload value.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous reset, active-high.
- `start` in 1: frame request; sampled only in IDLE.
- `abort` in 1: terminate the frame immediately.
- `img_width` in WIDTH_W: pixels per line; latched at start.
- `num_lines` in WIDTH_W: lines per frame; latched at start.
- `idle_cycles` in GAP_W: gap cycles between lines; latched at start.
- `mode` in 2: pattern select; latched at start.
- `solid_r`, `solid_g`, `solid_b` in 8 each: colour for solid mode; latched at start.
- `dout_ready` in 1: downstream accept; tie high for the preprocessing stage.
- `dout_valid` out 1: pixel valid.
- `r_data`, `g_data`, `b_data` out 8 each: pixel components.
- `pixel_cnt`, `line_cnt` out WIDTH_W: coordinates of the current pixel.
- `sol`, `eol` out 1: first / last pixel of line, qualified by `dout_valid`.
- `busy` out 1: high from accepted start until return to IDLE.
- `done` out 1: one-cycle pulse when a frame completes normally.

## Operation
- FSM states:
  - IDLE -> ACTIVE on `start`, only if width and lines are both nonzero.
  - IDLE -> DONE on `start` if width or lines is 0; no pixels are emitted.
  - ACTIVE -> GAP after the last pixel of a line transfers, if more lines remain and `idle_cycles` != 0.
  - ACTIVE -> ACTIVE (next line) in the same case when `idle_cycles` == 0.
  - ACTIVE -> DONE after the last pixel of the last line transfers; no trailing gap.
  - GAP -> ACTIVE after exactly `idle_cycles` cycles.
  - DONE -> IDLE after one cycle; `done` is high during DONE.
- Transfer rule: a pixel transfers on a cycle with `dout_valid && dout_ready`.
  - With `dout_ready` low, all outputs and counters hold.
  - `dout_valid` never drops mid-line while waiting.
- `pixel_cnt` wraps to 0 at `img_width`-1 and `line_cnt` increments. Counters reset to 0 on start.
- Patterns:
  - mode 0, solid: latched `solid_*`.
  - mode 1, gradient: r = pixel_cnt[7:0], g = line_cnt[7:0], b = pixel_cnt[7:0] ^ line_cnt[7:0].
  - mode 2, random: LFSR; see Configuration.
  - mode 3, checker: 8x8 cells; white (FF,FF,FF) when pixel_cnt[3] ^ line_cnt[3] is 1, else black (00,00,00).
- `abort` has priority over everything in every state:
  - FSM goes to IDLE and `dout_valid` and `busy` clear next cycle.
  - No `done` pulse.
- `start` while busy is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE, LFSR = LFSR_SEED.
- Latency: start accepted at edge N -> first pixel (`dout_valid`, `sol`) registered at edge N+1.
- Line length: with `dout_ready` high, a line is exactly `img_width` consecutive valid cycles. Period per line = `img_width` + `idle_cycles`.
- `done` is asserted the cycle after the last transfer. `busy` falls together with `done` returning low.
- `img_width` = 1: `sol` and `eol` are high on the same pixel.
- Reset mid-frame: immediate return to the reset values above.

## Configuration
- `PIXEL_GEN_LFSR_EN` defined: mode 2 uses a 24-bit Fibonacci LFSR.
  - Polynomial x^24+x^23+x^22+x^17+1; reloaded with LFSR_SEED on each accepted start.
  - Advances once per transfer; r = lfsr[23:16], g = lfsr[15:8], b = lfsr[7:0].
- Not defined: no LFSR logic is built and mode 2 behaves as mode 0 (solid).

## Structure
- Shared package holds:
  - mode encodings MODE_SOLID=0, MODE_GRADIENT=1, MODE_RANDOM=2, MODE_CHECKER=3;
  - FSM state enum (IDLE, ACTIVE, GAP, DONE);
  - LFSR tap constant.
- One sub-module, `pixel_pattern_lut`: combinational pattern mux taking latched config and counters and producing RGB. The LFSR register stays in the top so it can hold during stalls.

## Test plan
- Mode 0, solid (12,34,56), width 640, 3 lines, gap 20, ready high -> 3 bursts of 640 valid cycles each carrying (12,34,56). Exactly 20 invalid cycles between bursts. `done` pulses 1 cycle after pixel 1919.
- Mode 1, width 4, 2 lines, gap 0 -> 8 back-to-back pixels:
  - line 0: r = 0,1,2,3; line 1: g = 1, b = r^1.
  - `eol` on pixel_cnt 3 of each line.
- Width 0, or lines 0 -> `busy` high 1 cycle, `done` pulse, never `dout_valid`.
- Mode 3, width 16, ready toggled every other cycle -> still 16 unique pixels; pixels 0-7 black, 8-15 white; values held while ready low.
- Abort asserted at pixel 100 of line 1 -> `dout_valid` low next cycle, no `done`. A new start runs a clean frame with counters at 0.
- With `PIXEL_GEN_LFSR_EN`: mode 2, width 2 -> first pixel (5A,5A,5A), second pixel equal to the seed advanced one step. Two frames give an identical sequence. Without the macro -> mode 2 outputs `solid_*`.

Source files
------------

// File: rtl/pixel_stream_gen_pkg.sv
// Shared types and constants for pixel_stream_gen and its pattern mux.
package pixel_stream_gen_pkg;

  localparam logic [1:0] MODE_SOLID    = 2'd0;
  localparam logic [1:0] MODE_GRADIENT = 2'd1;
  localparam logic [1:0] MODE_RANDOM   = 2'd2;
  localparam logic [1:0] MODE_CHECKER  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_GAP,
    ST_DONE
  } state_e;

  // Taps for x^24+x^23+x^22+x^17+1 on a left-shifting Fibonacci register.
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;

  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    return {s[22:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pixel_stream_gen_pattern_lut.sv
// Combinational RGB pattern mux. Mode 2 uses the LFSR only when
// PIXEL_GEN_LFSR_EN is defined; otherwise it falls back to the solid colour.
module pixel_pattern_lut
  import pixel_stream_gen_pkg::*;
(
  input  logic [1:0]  mode,
  input  logic [7:0]  solid_r,
  input  logic [7:0]  solid_g,
  input  logic [7:0]  solid_b,
  input  logic [7:0]  pixel_x,
  input  logic [7:0]  line_y,
`ifdef PIXEL_GEN_LFSR_EN
  input  logic [23:0] lfsr,
`endif
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  always_comb begin
    r = solid_r;
    g = solid_g;
    b = solid_b;
    case (mode)
      MODE_GRADIENT: begin
        r = pixel_x;
        g = line_y;
        b = pixel_x ^ line_y;
      end
`ifdef PIXEL_GEN_LFSR_EN
      MODE_RANDOM: begin
        r = lfsr[23:16];
        g = lfsr[15:8];
        b = lfsr[7:0];
      end
`endif
      MODE_CHECKER: begin
        r = (pixel_x[3] ^ line_y[3]) ? 8'hFF : 8'h00;
        g = r;
        b = r;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pixel_stream_gen.sv
// RGB888 line/frame source with programmable idle gap between lines.
// Define PIXEL_GEN_LFSR_EN to build the LFSR random pattern for mode 2.
module pixel_stream_gen
  import pixel_stream_gen_pkg::*;
#(
  parameter int          WIDTH_W   = 12,
  parameter int          GAP_W     = 8,
  parameter logic [23:0] LFSR_SEED = 24'h5A5A5A
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH_W-1:0] img_width,
  input  logic [WIDTH_W-1:0] num_lines,
  input  logic [GAP_W-1:0]   idle_cycles,
  input  logic [1:0]         mode,
  input  logic [7:0]         solid_r,
  input  logic [7:0]         solid_g,
  input  logic [7:0]         solid_b,
  input  logic               dout_ready,
  output logic               dout_valid,
  output logic [7:0]         r_data,
  output logic [7:0]         g_data,
  output logic [7:0]         b_data,
  output logic [WIDTH_W-1:0] pixel_cnt,
  output logic [WIDTH_W-1:0] line_cnt,
  output logic               sol,
  output logic               eol,
  output logic               busy,
  output logic               done
);

  localparam logic [WIDTH_W-1:0] ONE_W = WIDTH_W'(1);
  localparam logic [GAP_W-1:0]   ONE_G = GAP_W'(1);

  state_e               state_q, state_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [WIDTH_W-1:0]   lines_q, lines_d;
  logic [WIDTH_W-1:0]   pix_q, pix_d;
  logic [WIDTH_W-1:0]   line_q, line_d;
  logic [GAP_W-1:0]     gap_cfg_q, gap_cfg_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [23:0]          solid_q, solid_d;
  logic                 xfer, last_pix, last_line;
  logic [7:0]           pat_r, pat_g, pat_b;

  assign xfer      = (state_q == ST_ACTIVE) && dout_ready;
  assign last_pix  = (pix_q == width_q - ONE_W);
  assign last_line = (line_q == lines_q - ONE_W);

  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    lines_d   = lines_q;
    pix_d     = pix_q;
    line_d    = line_q;
    gap_cfg_d = gap_cfg_q;
    gap_cnt_d = gap_cnt_q;
    mode_d    = mode_q;
    solid_d   = solid_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            width_d   = img_width;
            lines_d   = num_lines;
            gap_cfg_d = idle_cycles;
            mode_d    = mode;
            solid_d   = {solid_r, solid_g, solid_b};
            pix_d     = '0;
            line_d    = '0;
            state_d   = (img_width != '0 && num_lines != '0) ? ST_ACTIVE : ST_DONE;
          end
        end
        ST_ACTIVE: begin
          if (xfer) begin
            if (last_pix) begin
              pix_d = '0;
              if (last_line) begin
                state_d = ST_DONE;
              end else begin
                line_d = line_q + ONE_W;
                if (gap_cfg_q != '0) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = gap_cfg_q - ONE_G;
                end
              end
            end else begin
              pix_d = pix_q + ONE_W;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) state_d = ST_ACTIVE;
          else                 gap_cnt_d = gap_cnt_q - ONE_G;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      width_q   <= '0;
      lines_q   <= '0;
      pix_q     <= '0;
      line_q    <= '0;
      gap_cfg_q <= '0;
      gap_cnt_q <= '0;
      mode_q    <= MODE_SOLID;
      solid_q   <= '0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      lines_q   <= lines_d;
      pix_q     <= pix_d;
      line_q    <= line_d;
      gap_cfg_q <= gap_cfg_d;
      gap_cnt_q <= gap_cnt_d;
      mode_q    <= mode_d;
      solid_q   <= solid_d;
    end
  end

`ifdef PIXEL_GEN_LFSR_EN
  logic [23:0] lfsr_q, lfsr_d;

  // Reload on every accepted start, advance only on a real transfer.
  always_comb begin
    lfsr_d = lfsr_q;
    if (!abort) begin
      if (state_q == ST_IDLE && start) lfsr_d = LFSR_SEED;
      else if (xfer)                   lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
`endif

  pixel_pattern_lut u_lut (
    .mode    (mode_q),
    .solid_r (solid_q[23:16]),
    .solid_g (solid_q[15:8]),
    .solid_b (solid_q[7:0]),
    .pixel_x (pix_q[7:0]),
    .line_y  (line_q[7:0]),
`ifdef PIXEL_GEN_LFSR_EN
    .lfsr    (lfsr_q),
`endif
    .r       (pat_r),
    .g       (pat_g),
    .b       (pat_b)
  );

  assign dout_valid = (state_q == ST_ACTIVE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign pixel_cnt  = pix_q;
  assign line_cnt   = line_q;
  assign sol        = dout_valid && (pix_q == '0);
  assign eol        = dout_valid && last_pix;
  assign r_data     = dout_valid ? pat_r : 8'h00;
  assign g_data     = dout_valid ? pat_g : 8'h00;
  assign b_data     = dout_valid ? pat_b : 8'h00;

endmodule

// File: tb/tb_pixel_stream_gen.sv
// Self-checking bench for pixel_stream_gen: directed and randomized frames
// compared cycle by cycle against a nested-loop model of the pixel stream.
module tb_pixel_stream_gen;

  localparam logic [23:0] SEED = 24'h5A5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort, dout_ready;
  logic [11:0] img_width, num_lines;
  logic [7:0]  idle_cycles;
  logic [1:0]  mode;
  logic [7:0]  solid_r, solid_g, solid_b;
  logic        dout_valid, sol, eol, busy, done;
  logic [7:0]  r_data, g_data, b_data;
  logic [11:0] pixel_cnt, line_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] lfsr_m;

  pixel_stream_gen dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .img_width(img_width), .num_lines(num_lines), .idle_cycles(idle_cycles),
    .mode(mode), .solid_r(solid_r), .solid_g(solid_g), .solid_b(solid_b),
    .dout_ready(dout_ready), .dout_valid(dout_valid),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .pixel_cnt(pixel_cnt), .line_cnt(line_cnt),
    .sol(sol), .eol(eol), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One comparison: counts the vector and reports any miscompare.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference pixel colour straight from the pattern rules.
  function automatic logic [23:0] expPixel(input logic [1:0] md, input int x, input int y,
                                           input logic [23:0] solid, input logic [23:0] lf);
    logic [7:0] xr, yr;
    xr = 8'(x % 256);
    yr = 8'(y % 256);
    case (md)
      2'd1: return {xr, yr, xr ^ yr};
`ifdef PIXEL_GEN_LFSR_EN
      2'd2: return lf;
`endif
      2'd3: return ((((x / 8) + (y / 8)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      default: return solid;
    endcase
  endfunction

  // Taps at exponents 24, 23, 22 and 17, shifted toward the MSB.
  function automatic logic [23:0] modelStep(input logic [23:0] s);
    logic fb;
    fb = s[23] ^ s[22] ^ s[21] ^ s[16];
    return {s[22:0], fb};
  endfunction

  // Drives a frame request for one edge, then scrambles the config inputs
  // so the bench also shows that everything was latched at start.
  task automatic applyStimulus(input int w, input int lines, input int gap, input logic [1:0] md,
                               input logic [7:0] sr, input logic [7:0] sg, input logic [7:0] sb);
    img_width   = 12'(w);
    num_lines   = 12'(lines);
    idle_cycles = 8'(gap);
    mode        = md;
    solid_r     = sr;
    solid_g     = sg;
    solid_b     = sb;
    dout_ready  = 1'b1;
    start       = 1'b1;
    tick();
    start       = 1'b0;
    lfsr_m      = SEED;
    img_width   = 12'($urandom);
    num_lines   = 12'($urandom);
    idle_cycles = 8'($urandom);
    mode        = 2'($urandom);
    solid_r     = 8'($urandom);
    solid_g     = 8'($urandom);
    solid_b     = 8'($urandom);
  endtask

  task automatic checkPixel(input int x, input int y, input int w, input logic [23:0] exp);
    checkOutput("valid", 32'(dout_valid), 32'd1);
    checkOutput("pixel_cnt", 32'(pixel_cnt), 32'(x));
    checkOutput("line_cnt", 32'(line_cnt), 32'(y));
    checkOutput("sol", 32'(sol), 32'(x == 0));
    checkOutput("eol", 32'(eol), 32'(x == w - 1));
    checkOutput("rgb", 32'({r_data, g_data, b_data}), 32'(exp));
    checkOutput("busy_active", 32'(busy), 32'd1);
    checkOutput("done_active", 32'(done), 32'd0);
  endtask

  // rp: 0 = ready high, 1 = toggle each cycle, 2 = random.
  // ab_x/ab_y: pixel at which abort is raised (-1 for none).
  task automatic runFrame(input int w, input int lines, input int gap, input logic [1:0] md,
                          input logic [7:0] sr, input logic [7:0] sg, input logic [7:0] sb,
                          input int rp, input int ab_x, input int ab_y);
    logic [23:0] exp;
    logic        rdy;
    logic        tog;
    int          stalls;
    tog = 1'b0;
    applyStimulus(w, lines, gap, md, sr, sg, sb);
    if (w == 0 || lines == 0) begin
      checkOutput("empty_busy", 32'(busy), 32'd1);
      checkOutput("empty_done", 32'(done), 32'd1);
      checkOutput("empty_valid", 32'(dout_valid), 32'd0);
      tick();
      checkOutput("empty_busy_fall", 32'(busy), 32'd0);
      checkOutput("empty_done_fall", 32'(done), 32'd0);
      checkOutput("empty_valid_after", 32'(dout_valid), 32'd0);
      return;
    end
    for (int y = 0; y < lines; y++) begin
      for (int x = 0; x < w; x++) begin
        exp = expPixel(md, x, y, {sr, sg, sb}, lfsr_m);
        if (x == ab_x && y == ab_y) begin
          checkPixel(x, y, w, exp);
          abort = 1'b1;
          dout_ready = 1'b1;
          tick();
          abort = 1'b0;
          checkOutput("abort_valid", 32'(dout_valid), 32'd0);
          checkOutput("abort_busy", 32'(busy), 32'd0);
          for (int k = 0; k < 4; k++) begin
            checkOutput("abort_no_done", 32'(done), 32'd0);
            tick();
          end
          return;
        end
        stalls = 0;
        do begin
          case (rp)
            0:       rdy = 1'b1;
            1:       begin tog = ~tog; rdy = tog; end
            default: rdy = ($urandom_range(0, 2) != 0);
          endcase
          if (stalls >= 8) rdy = 1'b1;
          dout_ready = rdy;
          start = 1'($urandom_range(0, 1));
          checkPixel(x, y, w, exp);
          tick();
          stalls++;
        end while (!rdy);
        start = 1'b0;
        lfsr_m = modelStep(lfsr_m);
      end
      if (y < lines - 1) begin
        for (int g = 0; g < gap; g++) begin
          checkOutput("gap_valid", 32'(dout_valid), 32'd0);
          checkOutput("gap_busy", 32'(busy), 32'd1);
          tick();
        end
      end
    end
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_valid", 32'(dout_valid), 32'd0);
    tick();
    checkOutput("done_fall", 32'(done), 32'd0);
    checkOutput("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    dout_ready = 1'b0;
    img_width = '0;
    num_lines = '0;
    idle_cycles = '0;
    mode = '0;
    solid_r = '0;
    solid_g = '0;
    solid_b = '0;
    lfsr_m = SEED;
    repeat (2) tick();
    checkOutput("rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sol_eol", 32'({sol, eol}), 32'd0);
    checkOutput("rst_counters", 32'({pixel_cnt, line_cnt}), 32'd0);
    checkOutput("rst_rgb", 32'({r_data, g_data, b_data}), 32'd0);
    rst = 1'b0;
    tick();

    $display("[TB] solid 640x3 with gap 20");
    runFrame(640, 3, 20, 2'd0, 8'd12, 8'd34, 8'd56, 0, -1, -1);
    $display("[TB] gradient 4x2 back to back");
    runFrame(4, 2, 0, 2'd1, 8'd0, 8'd0, 8'd0, 0, -1, -1);
    $display("[TB] empty frames");
    runFrame(0, 3, 4, 2'd0, 8'd1, 8'd2, 8'd3, 0, -1, -1);
    runFrame(5, 0, 4, 2'd0, 8'd1, 8'd2, 8'd3, 0, -1, -1);
    $display("[TB] checker 16 wide with toggled ready");
    runFrame(16, 1, 3, 2'd3, 8'd9, 8'd9, 8'd9, 1, -1, -1);
    runFrame(20, 10, 1, 2'd3, 8'd0, 8'd0, 8'd0, 2, -1, -1);
    $display("[TB] random mode, two identical frames");
    runFrame(2, 1, 0, 2'd2, 8'd1, 8'd2, 8'd3, 0, -1, -1);
    runFrame(2, 1, 0, 2'd2, 8'd1, 8'd2, 8'd3, 0, -1, -1);
    runFrame(9, 3, 2, 2'd2, 8'd4, 8'd5, 8'd6, 2, -1, -1);
    $display("[TB] single-pixel lines");
    runFrame(1, 3, 1, 2'd1, 8'd0, 8'd0, 8'd0, 2, -1, -1);
    $display("[TB] abort at pixel 100 of line 1, then clean frame");
    runFrame(150, 3, 5, 2'd1, 8'd0, 8'd0, 8'd0, 0, 100, 1);
    runFrame(3, 2, 2, 2'd1, 8'd0, 8'd0, 8'd0, 2, -1, -1);
    $display("[TB] randomized frames");
    for (int f = 0; f < 6; f++) begin
      runFrame(int'($urandom_range(1, 20)), int'($urandom_range(1, 4)), int'($urandom_range(0, 5)),
               2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 2, -1, -1);
    end

    $display("[TB] reset mid-frame");
    applyStimulus(50, 2, 3, 2'd1, 8'd0, 8'd0, 8'd0);
    dout_ready = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(dout_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_counters", 32'({pixel_cnt, line_cnt}), 32'd0);
    checkOutput("midrst_rgb", 32'({r_data, g_data, b_data}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    runFrame(5, 2, 1, 2'd2, 8'd7, 8'd8, 8'd9, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
